// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for one matrix-multiply job on the systolic datapath.
// On an accepted start it pulses the array clear, streams K operand vectors from
// the Fetchers, drains the skew pipeline, waits for the array's ready and holds
// the result until the consumer acks.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   i_start, i_k_len  job request (sampled only in IDLE) and reduction length
//   i_stall           feed back-pressure, only meaningful in FEED
//   i_array_ready     array result ready
//   i_result_ack      consumer has taken the result
//   o_busy            high in every state except IDLE
//   o_array_clear     accumulator clear, one cycle
//   o_feed/o_skew_valid/o_feed_addr   operand beat strobe and index
//   o_result_valid    result is final (HOLD)
//   o_done            one-cycle pulse after job end
//   o_err             watchdog fired, sticky until next start
//
// Build option: define SYS_CTRL_TIMEOUT_EN to add the WAIT/HOLD watchdog.
// Without it the controller waits indefinitely and o_err is tied low.
//
// State | meaning
// IDLE  | no job; accept start
// CLEAR | clear array accumulators
// FEED  | stream K operand beats
// DRAIN | let skew pipeline empty
// WAIT  | wait for array ready
// HOLD  | result valid until ack

`ifndef SYS_ARRAY_LEN
`define SYS_ARRAY_LEN 4
`endif

module systolic_ctrl #(
  parameter int ARRAY_LEN      = `SYS_ARRAY_LEN,
  parameter int K_MAX          = 256,
  parameter int KW             = $clog2(K_MAX + 1),
  parameter int AW             = $clog2(K_MAX),
  parameter int DRAIN_CYCLES   = 2 * ARRAY_LEN,
  parameter int TIMEOUT_CYCLES = 500
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic [KW-1:0] i_k_len,
  input  logic          i_stall,
  input  logic          i_array_ready,
  input  logic          i_result_ack,
  output logic          o_busy,
  output logic          o_array_clear,
  output logic          o_feed,
  output logic [AW-1:0] o_feed_addr,
  output logic          o_skew_valid,
  output logic          o_result_valid,
  output logic          o_done,
  output logic          o_err
);

  localparam int CW = $clog2(DRAIN_CYCLES + TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_WAIT, S_HOLD} state_t;

  state_t        r_state, w_next;
  logic [KW-1:0] r_k;
  logic [AW-1:0] r_addr;
  logic [CW-1:0] r_cnt;
  logic          r_rdy_seen;
  logic          r_done;
  logic [KW-1:0] w_k_sat;
  logic [AW-1:0] w_last_addr;
  logic          w_last_beat;
  logic          w_tmo_fire;

  assign w_k_sat     = (i_k_len > KW'(K_MAX)) ? KW'(K_MAX) : i_k_len;
  assign w_last_addr = AW'(r_k - KW'(1));
  assign w_last_beat = (r_state == S_FEED) && !i_stall && (r_addr == w_last_addr);

`ifdef SYS_CTRL_TIMEOUT_EN
  logic r_err;
  // r_cnt is reloaded with the watchdog limit on DRAIN exit and keeps
  // counting down across WAIT and HOLD as one budget.
  assign w_tmo_fire = ((r_state == S_WAIT) || (r_state == S_HOLD)) && (r_cnt == '0);
  assign o_err      = r_err;
`else
  assign w_tmo_fire = 1'b0;
  assign o_err      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = (w_k_sat == '0) ? S_IDLE : S_CLEAR;
      S_CLEAR: w_next = S_FEED;
      S_FEED:  if (w_last_beat) w_next = S_DRAIN;
      S_DRAIN: if (r_cnt == '0) w_next = S_WAIT;
      S_WAIT: begin
        if (w_tmo_fire)                        w_next = S_IDLE;
        else if (i_array_ready || r_rdy_seen) w_next = S_HOLD;
      end
      S_HOLD:  if (w_tmo_fire || i_result_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy         = (r_state != S_IDLE);
    o_array_clear  = (r_state == S_CLEAR);
    o_feed         = (r_state == S_FEED) && !i_stall;
    o_skew_valid   = (r_state == S_FEED) && !i_stall;
    o_result_valid = (r_state == S_HOLD);
    o_feed_addr    = r_addr;
    o_done         = r_done;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k        <= '0;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_rdy_seen <= 1'b0;
      r_done     <= 1'b0;
`ifdef SYS_CTRL_TIMEOUT_EN
      r_err      <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_k        <= w_k_sat;
          r_addr     <= '0;
          r_rdy_seen <= 1'b0;
          // zero-length job finishes immediately
          r_done     <= (w_k_sat == '0);
`ifdef SYS_CTRL_TIMEOUT_EN
          r_err      <= 1'b0;
`endif
        end
        S_FEED: begin
          if (w_last_beat)   r_cnt  <= CW'(DRAIN_CYCLES - 1);
          else if (!i_stall) r_addr <= r_addr + AW'(1);
        end
        S_DRAIN: begin
          if (i_array_ready) r_rdy_seen <= 1'b1;
          if (r_cnt != '0)   r_cnt <= r_cnt - CW'(1);
`ifdef SYS_CTRL_TIMEOUT_EN
          else               r_cnt <= CW'(TIMEOUT_CYCLES - 1);
`endif
        end
        S_WAIT, S_HOLD: begin
`ifdef SYS_CTRL_TIMEOUT_EN
          if (w_tmo_fire) begin
            r_err  <= 1'b1;
            r_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
`endif
          if ((r_state == S_HOLD) && i_result_ack) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
